// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-block memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BLOCK_WORDS_DEF = 4;

    localparam int IC = 0;
    localparam int DC = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer names the requester favoured on a tie.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[IC] && i_req[DC]) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end else if (i_req[IC]) begin
            o_gnt = 2'b01;
        end else if (i_req[DC]) begin
            o_gnt = 2'b10;
        end
    end

    // After a grant the other requester becomes favoured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept && (o_gnt != 2'b00)) begin
            r_ptr <= o_gnt[IC];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-wide memory between icache and dcache block fills and write-backs.
//   state    | meaning
//   ST_IDLE  | no transfer; arbitrate and latch the winner's request
//   ST_WRITE | one beat per cycle, write strobe high
//   ST_READ  | BLOCK_WORDS address beats plus one trailing capture cycle
//   ST_DONE  | one-cycle done pulse to the owner
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int ADDR_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    req,
    input  logic [1:0]                    we,
    input  logic [2*ADDR_W-1:0]           addr,
    input  logic [2*32*BLOCK_WORDS-1:0]   wdata,
    output logic [1:0]                    grant,
    output logic [1:0]                    done,
    output logic [32*BLOCK_WORDS-1:0]     rdata,
    output logic                          busy,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [31:0]                   mem_data_in,
    output logic                          mem_write_enable,
    input  logic [31:0]                   mem_data_out
);

    localparam int BLK_BITS = 32 * BLOCK_WORDS;
    localparam int IDX_W    = $clog2(BLOCK_WORDS);
    localparam int CNT_W    = IDX_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BLOCK_WORDS - 1));
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  TAIL_BEAT  = CNT_W'(BLOCK_WORDS);

    state_t                        r_state;
    logic [1:0]                    r_grant;
    logic [1:0]                    r_done;
    logic                          r_busy;
    logic [ADDR_W-1:0]             r_base;
    logic [ADDR_W-1:0]             r_mem_addr;
    logic [31:0]                   r_mem_din;
    logic                          r_mem_we;
    logic [CNT_W-1:0]              r_beat;
    logic [BLOCK_WORDS-1:0][31:0]  r_wdata;
    logic [BLOCK_WORDS-1:0][31:0]  r_fill;
    logic [BLOCK_WORDS-1:0][31:0]  r_rdata;

    logic [1:0]                    w_gnt;
    logic                          w_accept;
    logic                          w_win;
    logic                          w_win_we;
    logic [ADDR_W-1:0]             w_win_addr;
    logic [BLK_BITS-1:0]           w_win_wdata;
    logic [CNT_W-1:0]              w_beat_nxt;
    logic [ADDR_W-1:0]             w_addr_nxt;
    logic [IDX_W-1:0]              w_rd_idx;
    logic [BLOCK_WORDS-1:0][31:0]  w_fill_nxt;

    assign w_accept = (r_state == ST_IDLE) && (req != 2'b00);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (req),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    assign w_win       = w_gnt[DC];
    assign w_win_we    = w_win ? we[DC] : we[IC];
    assign w_win_addr  = w_win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    assign w_win_wdata = w_win ? wdata[2*BLK_BITS-1:BLK_BITS] : wdata[BLK_BITS-1:0];

    assign w_beat_nxt = r_beat + 1'b1;
    assign w_addr_nxt = r_base + ADDR_W'(w_beat_nxt);
    // Read data trails its address by one cycle, so cycle k fills word k-1.
    assign w_rd_idx   = IDX_W'(r_beat - 1'b1);

    always_comb begin
        w_fill_nxt           = r_fill;
        w_fill_nxt[w_rd_idx] = mem_data_out;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'b00;
            r_done     <= 2'b00;
            r_busy     <= 1'b0;
            r_base     <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_beat     <= '0;
            r_wdata    <= '0;
            r_fill     <= '0;
            r_rdata    <= '0;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant    <= w_gnt;
                        r_busy     <= 1'b1;
                        r_base     <= w_win_addr & ALIGN_MASK;
                        r_mem_addr <= w_win_addr & ALIGN_MASK;
                        r_wdata    <= w_win_wdata;
                        r_beat     <= '0;
                        if (w_win_we) begin
                            r_state   <= ST_WRITE;
                            r_mem_we  <= 1'b1;
                            r_mem_din <= w_win_wdata[31:0];
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (r_beat == LAST_BEAT) begin
                        r_state  <= ST_DONE;
                        r_mem_we <= 1'b0;
                        r_done   <= r_grant;
                    end else begin
                        r_beat     <= w_beat_nxt;
                        r_mem_addr <= w_addr_nxt;
                        r_mem_din  <= r_wdata[w_beat_nxt[IDX_W-1:0]];
                    end
                end
                ST_READ: begin
                    if (r_beat != '0) begin
                        r_fill <= w_fill_nxt;
                    end
                    // rdata is published whole so it only ever shows completed fills.
                    if (r_beat == TAIL_BEAT) begin
                        r_state <= ST_DONE;
                        r_done  <= r_grant;
                        r_rdata <= w_fill_nxt;
                    end else begin
                        r_beat <= w_beat_nxt;
                        if (r_beat != LAST_BEAT) begin
                            r_mem_addr <= w_addr_nxt;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant            = r_grant;
    assign done             = r_done;
    assign busy             = r_busy;
    assign rdata            = r_rdata;
    assign mem_address      = r_mem_addr;
    assign mem_data_in      = r_mem_din;
    assign mem_write_enable = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transfer-level reference model.
module tb_mem_arbiter;

    localparam int BW = 4;

    logic           clk;
    logic           reset_n;
    logic [1:0]     req;
    logic [1:0]     we;
    logic [63:0]    addr;
    logic [255:0]   wdata;
    logic [1:0]     grant;
    logic [1:0]     done;
    logic [127:0]   rdata;
    logic           busy;
    logic [31:0]    mem_address;
    logic [31:0]    mem_data_in;
    logic           mem_write_enable;
    logic [31:0]    mem_data_out;

    mem_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .grant            (grant),
        .done             (done),
        .rdata            (rdata),
        .busy             (busy),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: unwritten word n reads as n.
    logic [31:0] mem_arr [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a;
    endfunction

    always @(posedge clk) begin
        mem_data_out <= mem_rd(mem_address);
        if (mem_write_enable) mem_arr[mem_address] = mem_data_in;
    end

    // Reference model: expected memory image, pointer and last fill block.
    logic [31:0]  ref_mem [logic [31:0]];
    int           ref_ptr;
    logic [127:0] ref_rdata;
    logic [1:0]   last_gnt;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a;
    endfunction

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 63));
    endfunction

    // Called in an IDLE cycle; returns in the IDLE cycle after the transfer.
    task automatic xfer(input logic [1:0] rq, input logic [1:0] wv,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [127:0] d0, input logic [127:0] d1,
                        input bit scramble, input bit keep);
        int           w;
        int           lat;
        bit           iswr;
        logic [1:0]   oh;
        logic [31:0]  base;
        logic [127:0] wd;
        req   = rq;
        we    = wv;
        addr  = {a1, a0};
        wdata = {d1, d0};
        w       = (rq == 2'b11) ? ref_ptr : (rq[1] ? 1 : 0);
        ref_ptr = 1 - w;
        oh      = (w == 1) ? 2'b10 : 2'b01;
        base    = ((w == 1) ? a1 : a0) & 32'hFFFF_FFFC;
        wd      = (w == 1) ? d1 : d0;
        iswr    = wv[w];
        lat     = iswr ? BW + 1 : BW + 2;
        for (int k = 0; k < BW; k++) begin
            if (iswr) ref_mem[base + 32'(k)] = wd[32*k +: 32];
            else      ref_rdata[32*k +: 32] = ref_rd(base + 32'(k));
        end
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) last_gnt = grant;
            if (scramble && c == 1) begin
                we    = 2'($urandom);
                addr  = {$urandom, $urandom};
                wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
            end
            if (c < lat) begin
                chk("ctl", {grant, done, busy}, {oh, 2'b00, 1'b1});
                if (iswr)
                    chk("wr_beat", {mem_write_enable, mem_address, mem_data_in},
                        {1'b1, base + 32'(c - 1), wd[32*(c-1) +: 32]});
                else
                    chk("rd_beat", {mem_write_enable, mem_address},
                        {1'b0, base + 32'((c - 1 < BW - 1) ? c - 1 : BW - 1)});
            end else begin
                chk("done", {grant, done, busy, mem_write_enable}, {oh, oh, 1'b1, 1'b0});
                chk("rdata", rdata, ref_rdata);
                if (!keep) req[w] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("idle", {grant, done, busy, mem_write_enable, mem_address, rdata},
            {2'b00, 2'b00, 1'b0, 1'b0, base + 32'(BW - 1), ref_rdata});
    endtask

    logic [1:0]   obs [4];
    logic [127:0] blk;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        ref_ptr   = 0;
        ref_rdata = '0;
        reset_n   = 1'b0;
        req       = 2'b00;
        we        = 2'b00;
        addr      = '0;
        wdata     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {grant, done, busy, mem_write_enable, mem_address, mem_data_in, rdata}, '0);
        reset_n = 1'b1;

        // Single dcache fill of block 0x10.
        xfer(2'b10, 2'b00, 32'h0, 32'h13, '0, '0, 0, 0);
        chk("fill_rdata", rdata, {32'h13, 32'h12, 32'h11, 32'h10});

        // icache write-back to 0x20, then a fill of the same block.
        blk = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        xfer(2'b01, 2'b01, 32'h20, 32'h0, blk, '0, 0, 0);
        chk("wb_keeps_rdata", rdata, {32'h13, 32'h12, 32'h11, 32'h10});
        xfer(2'b10, 2'b00, 32'h0, 32'h21, '0, '0, 0, 0);
        chk("wb_readback", rdata, blk);

        // Continuous contention alternates owners.
        for (int i = 0; i < 4; i++) begin
            xfer(2'b11, 2'b01, 32'h30, 32'h34,
                 {$urandom, $urandom, $urandom, $urandom}, '0, 0, 1);
            obs[i] = last_gnt;
        end
        chk("rr_seq", {obs[3], obs[2], obs[1], obs[0]}, {2'b10, 2'b01, 2'b10, 2'b01});

        // Fill at the top of the address space wraps nowhere past 0xFFFFFFFF.
        xfer(2'b10, 2'b00, 32'h0, 32'hFFFF_FFFE, '0, '0, 0, 0);
        chk("wrap_rdata", rdata, {32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC});

        for (int i = 0; i < 40; i++) begin
            xfer(2'($urandom_range(1, 3)), 2'($urandom), rand_addr(), rand_addr(),
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 bit'($urandom_range(0, 1)), 0);
        end

        // Reset during beat 2 of an icache write-back to 0x40.
        blk   = {$urandom, $urandom, $urandom, $urandom};
        req   = 2'b01;
        we    = 2'b01;
        addr  = {32'h0, 32'h40};
        wdata = {128'h0, blk};
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_beat2", {mem_write_enable, mem_address, mem_data_in}, {1'b1, 32'h42, blk[95:64]});
        reset_n = 1'b0;
        req     = 2'b00;
        #1;
        chk("rst_outputs", {grant, done, busy, mem_write_enable, mem_address, mem_data_in, rdata}, '0);
        ref_ptr   = 0;
        ref_rdata = '0;
        ref_mem[32'h40] = blk[31:0];
        ref_mem[32'h41] = blk[63:32];
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", {done, busy}, '0);
        end
        chk("rst_mem", {mem_rd(32'h43), mem_rd(32'h42), mem_rd(32'h41), mem_rd(32'h40)},
            {ref_rd(32'h43), ref_rd(32'h42), ref_rd(32'h41), ref_rd(32'h40)});
        reset_n = 1'b1;
        xfer(2'b11, 2'b00, 32'h40, 32'h40, '0, '0, 0, 0);
        chk("rst_ptr", last_gnt, 2'b01);
        chk("rst_readback", rdata, {32'h43, 32'h42, blk[63:32], blk[31:0]});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
